// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Op codes, FSM encodings and divider constants.
package mdu_pkg;

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_UMULL = 3'b001;
    localparam logic [2:0] OP_SMULL = 3'b010;
    localparam logic [2:0] OP_UMLAL = 3'b011;
    localparam logic [2:0] OP_SMLAL = 3'b100;
    localparam logic [2:0] OP_MLS   = 3'b101;
    localparam logic [2:0] OP_UDIV  = 3'b110;
    localparam logic [2:0] OP_SDIV  = 3'b111;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int DIV_STEPS = 32;

    typedef struct packed {
        logic [31:0] rem;
        logic [31:0] quo;
    } div_state_t;

    function automatic logic [31:0] abs32(logic [31:0] v, logic sgn);
        return (sgn && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// Request/response bundle between a core and the MDU sequencer.
// The requester owns start/op/operands/flush; the MDU owns status and results.
interface mdu_sequencer_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] c;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] hi_result;
    logic        div_zero;

    modport master (
        output start, op, a, b, c, flush,
        input  busy, done, result, hi_result, div_zero
    );

    modport slave (
        input  start, op, a, b, c, flush,
        output busy, done, result, hi_result, div_zero
    );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
// The 33-bit trial subtraction borrow decides restore vs. keep.
module div_step
    import mdu_pkg::*;
(
    input  div_state_t  cur,
    input  logic [31:0] divisor,
    output div_state_t  nxt
);
    logic [32:0] sh;
    logic [32:0] diff;

    assign sh   = {cur.rem, cur.quo[31]};
    assign diff = sh - {1'b0, divisor};

    always_comb begin
        nxt.quo = {cur.quo[30:0], ~diff[32]};
        nxt.rem = diff[32] ? sh[31:0] : diff[31:0];
    end
endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer: single-cycle MUL stage,
// 32-step restoring divider with sign fixup, flushable at any point.
module mdu_sequencer
    import mdu_pkg::*;
(
    input logic           clk,
    input logic           reset,
    mdu_sequencer_if.slave bus
);
    logic [2:0]  state;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] c_q;
    logic [5:0]  cnt;
    logic [31:0] dvsr;
    div_state_t  div_q;
    div_state_t  div_nxt;
    logic [63:0] res_q;
    logic        rdz_q;
    logic        done_q;
    logic [31:0] result_q;
    logic [31:0] hi_q;
    logic        dz_q;

    logic [63:0] prod_u;
    logic [63:0] prod_s;
    logic [63:0] mul_res;
    logic        is_sdiv;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    div_step u_step (
        .cur     (div_q),
        .divisor (dvsr),
        .nxt     (div_nxt)
    );

    assign prod_u = {32'h0, a_q} * {32'h0, b_q};
    // Low 64 bits of the sign-extended product equal the signed product.
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};

    always_comb begin
        mul_res = '0;
        unique case (1'b1)
            op_q == OP_MUL:   mul_res = {32'h0, prod_u[31:0]};
            op_q == OP_UMULL: mul_res = prod_u;
            op_q == OP_SMULL: mul_res = prod_s;
            op_q == OP_UMLAL: mul_res = c_q + prod_u;
            op_q == OP_SMLAL: mul_res = c_q + prod_s;
            op_q == OP_MLS:   mul_res = {32'h0, c_q[31:0] - prod_u[31:0]};
            default:          mul_res = '0;
        endcase
    end

    assign is_sdiv = op_q == OP_SDIV;
    assign q_fix = (is_sdiv && (a_q[31] ^ b_q[31])) ? -div_q.quo : div_q.quo;
    assign r_fix = (is_sdiv && a_q[31]) ? -div_q.rem : div_q.rem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            cnt      <= '0;
            dvsr     <= '0;
            div_q    <= '0;
            res_q    <= '0;
            rdz_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            dz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state != S_IDLE && bus.flush) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (bus.start) begin
                        op_q      <= bus.op;
                        a_q       <= bus.a;
                        b_q       <= bus.b;
                        c_q       <= bus.c;
                        cnt       <= '0;
                        div_q.rem <= '0;
                        div_q.quo <= abs32(bus.a, bus.op == OP_SDIV);
                        dvsr      <= abs32(bus.b, bus.op == OP_SDIV);
                        if (bus.op[2:1] == 2'b11) begin
                            if (bus.b == '0) begin
                                res_q <= '0;
                                rdz_q <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                state <= S_DIV;
                            end
                        end else begin
                            state <= S_MUL;
                        end
                    end
                    S_MUL: begin
                        res_q <= mul_res;
                        rdz_q <= 1'b0;
                        state <= S_DONE;
                    end
                    S_DIV: begin
                        div_q <= div_nxt;
                        if (cnt == 6'(DIV_STEPS - 1)) begin
                            cnt   <= '0;
                            state <= S_FIX;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                    S_FIX: begin
                        res_q <= {r_fix, q_fix};
                        rdz_q <= 1'b0;
                        state <= S_DONE;
                    end
                    // Visible outputs only change here, so a flush leaves them intact.
                    S_DONE: begin
                        result_q <= res_q[31:0];
                        hi_q     <= res_q[63:32];
                        dz_q     <= rdz_q;
                        done_q   <= 1'b1;
                        state    <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy      = state != S_IDLE;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.hi_result = hi_q;
    assign bus.div_zero  = dz_q;
endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1, request strobe; sampled only in IDLE.
REQ-004 SHALL have port op, input, 3, operation code; encodings in REQ-024.
REQ-005 SHALL have ports a and b, inputs, 32 each, operands; c, input, 64, accumulator {hi,lo}.
REQ-006 SHALL have port flush, input, 1, abort of the in-flight operation.
REQ-007 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-009 SHALL have ports result and hi_result, outputs, 32 each, low and high result words.
REQ-010 SHALL have port div_zero, output, 1, divide-by-zero flag, valid while done is high.

Function
REQ-011 SHALL implement states IDLE, MUL, DIV, FIX, DONE.
REQ-012 SHALL accept start in IDLE only; start outside IDLE SHALL be ignored, with no queuing.
REQ-013 SHALL latch op, a, b and c on the accepting edge; later input changes SHALL have no effect on the operation.
REQ-014 SHALL sequence multiply ops (000-101) IDLE->MUL->DONE, giving done exactly 2 cycles after the accepting edge.
REQ-015 SHALL compute the full product in MUL with the add/subtract against c, and register the result at the end of MUL.
REQ-016 SHALL sequence divide ops (110, 111) with b!=0 as IDLE->DIV (32 cycles)->FIX->DONE, giving done 34 cycles after acceptance.
REQ-017 SHALL perform one radix-2 restoring step per DIV cycle on operand magnitudes, using a 6-bit iteration counter from 0 to 31.
REQ-018 SHALL apply sign fixup in FIX: quotient negated iff a[31]^b[31]; remainder takes the sign of a.
REQ-019 SHALL, for divide with b==0, go IDLE->DONE with result=0, hi_result=0, div_zero=1, done 1 cycle after acceptance.
REQ-020 SHALL return SDIV 0x80000000 / 0xFFFFFFFF as result=0x80000000, hi_result=0, div_zero=0.
REQ-021 SHALL put the quotient on result and the remainder on hi_result for divides.
REQ-022 SHALL hold result, hi_result and div_zero stable from done until the next accepted start.
REQ-023 SHALL, on flush in any non-IDLE state, return to IDLE next cycle with no done pulse and the outputs unchanged; flush in IDLE SHALL be ignored; flush has priority over completion in DONE.
REQ-024 SHALL decode op as follows:
- 000 MUL: lo(a*b), hi=0.
- 001 UMULL: unsigned 64-bit a*b.
- 010 SMULL: signed 64-bit a*b.
- 011 UMLAL: c + unsigned a*b, mod 2^64.
- 100 SMLAL: c + signed a*b, mod 2^64.
- 101 MLS: c[31:0] - lo(a*b), hi=0.
- 110 UDIV.
- 111 SDIV.
REQ-025 SHALL go DONE->IDLE unconditionally; start may be accepted on the cycle after done.

Reset
REQ-026 SHALL, on reset, enter IDLE and clear busy, done, result, hi_result, div_zero and the iteration counter to 0 immediately and asynchronously.
REQ-027 SHALL, on reset mid-operation, discard the operation with no done pulse after release.

Structure
REQ-028 SHALL place the op encodings, state encodings and DIV_STEPS=32 in shared package mdu_pkg.
REQ-029 SHALL implement a single sub-module div_step: a combinational restoring step taking {rem, quo, divisor} and returning the next {rem, quo}.

Verification
REQ-030 SHALL cover SMULL a=0xFFFFFFFE, b=3 -> done at acceptance+2, {hi_result,result}=0xFFFFFFFF_FFFFFFFA.
REQ-031 SHALL cover UMLAL a=0xFFFFFFFF, b=2, c=0x1 -> {hi_result,result}=0x00000001_FFFFFFFF.
REQ-032 SHALL cover SDIV a=-7, b=2 -> done at acceptance+34, result=0xFFFFFFFD, hi_result=0xFFFFFFFF.
REQ-033 SHALL cover UDIV b=0 -> done at acceptance+1, result=0, div_zero=1.
REQ-034 SHALL cover start reasserted while busy during a UDIV 100/7, then flush at cycle 10 -> only one operation runs, no done pulse, IDLE next cycle, prior result held.
REQ-035 SHALL cover reset asserted at DIV cycle 20 -> busy=0 and all outputs 0 immediately, with no done pulse after release.
